rsc_constituent_encoder: RTL and testbench

- One LTE turbo constituent encoder (RSC): g0 = 1+D^2+D^3 as feedback, g1 = 1+D+D^3 as feedforward, with a block-length counter and trellis termination.
- Two instances feed the tail processor: the natural-order instance drives x1/z1/q01/q11, the interleaved-order instance drives x2/z2.
- Produces systematic bit x and parity bit z per input bit, then exposes the shift-register state and a tailbits strobe so the downstream stage can form the 12 tail bits.

---
 rtl/rsc_constituent_encoder_if.sv | 42 ++++
 rtl/rsc_constituent_encoder.sv | 132 +++++++++++++
 tb/tb_rsc_constituent_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsc_constituent_encoder_if.sv
// Handshake/data bundle between an RSC constituent encoder and its producer/consumer.
// Carries block start/length, the bit stream in, x/z out, register taps and status strobes.
// Optional abort line is present only when RSC_ABORT_EN is defined.
interface rsc_constituent_encoder_if #(
    parameter int KW = 13
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          out_valid;
    logic          x;
    logic          z;
    logic          q0;
    logic          q1;
    logic          tailbits;
    logic          busy;
    logic          done;
    logic          len_err;
`ifdef RSC_ABORT_EN
    logic          abort;

    modport master (
        output start, k_len, in_valid, in_bit, abort,
        input  in_ready, out_valid, x, z, q0, q1, tailbits, busy, done, len_err
    );
    modport slave (
        input  start, k_len, in_valid, in_bit, abort,
        output in_ready, out_valid, x, z, q0, q1, tailbits, busy, done, len_err
    );
`else
    modport master (
        output start, k_len, in_valid, in_bit,
        input  in_ready, out_valid, x, z, q0, q1, tailbits, busy, done, len_err
    );
    modport slave (
        input  start, k_len, in_valid, in_bit,
        output in_ready, out_valid, x, z, q0, q1, tailbits, busy, done, len_err
    );
`endif
endinterface

// File: rtl/rsc_constituent_encoder.sv
// LTE turbo RSC constituent encoder (fb 1+D^2+D^3, ff 1+D+D^3) with length count and 3-cycle termination.
// Latency: x/z registered, 1 cycle after an accepted bit; done 4 cycles after the K-th accepted bit.
// Backpressure: in_ready high only in DATA; optional abort input exists only under RSC_ABORT_EN.
module rsc_constituent_encoder #(
    parameter int KW   = 13,
    parameter int KMIN = 40,
    parameter int KMAX = 6144
) (
    input  logic                     clk,
    input  logic                     reset,
    rsc_constituent_encoder_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;

    localparam logic [KW-1:0] KMIN_W = KW'(KMIN);
    localparam logic [KW-1:0] KMAX_W = KW'(KMAX);

    logic [1:0]    state;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] count;
    logic [KW-1:0] k_last;
    logic [1:0]    tcnt;
    logic          s1, s2, s3;   // s1 is the newest register bit
    logic          fb;
    logic          k_ok;
    logic          abort_hit;

    // Feedback term and length legality, evaluated combinationally for the current cycle.
    assign fb     = bus.in_bit ^ s2 ^ s3;
    assign k_ok   = (bus.k_len >= KMIN_W) && (bus.k_len <= KMAX_W);
    assign k_last = k_reg - 1'b1;

`ifdef RSC_ABORT_EN
    assign abort_hit = bus.abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Status outputs follow the state register directly.
    assign bus.in_ready = (state == DATA);
    assign bus.busy     = (state != IDLE);

    // Main FSM, trellis registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            k_reg         <= '0;
            count         <= '0;
            tcnt          <= '0;
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.x         <= 1'b0;
            bus.z         <= 1'b0;
            bus.q0        <= 1'b0;
            bus.q1        <= 1'b0;
            bus.tailbits  <= 1'b0;
            bus.done      <= 1'b0;
            bus.len_err   <= 1'b0;
        end else begin
            // Strobes default low; q0/q1 show the register value seen by the cycle that produced x/z.
            bus.out_valid <= 1'b0;
            bus.tailbits  <= 1'b0;
            bus.done      <= 1'b0;
            bus.len_err   <= 1'b0;
            bus.q0        <= s2;
            bus.q1        <= s3;

            if (abort_hit) begin
                state <= IDLE;
                count <= '0;
                tcnt  <= '0;
                s1    <= 1'b0;
                s2    <= 1'b0;
                s3    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (k_ok) begin
                                k_reg <= bus.k_len;
                                count <= '0;
                                s1    <= 1'b0;
                                s2    <= 1'b0;
                                s3    <= 1'b0;
                                state <= DATA;
                            end else begin
                                bus.len_err <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.in_valid) begin
                            bus.x         <= bus.in_bit;
                            bus.z         <= fb ^ s1 ^ s3;
                            bus.out_valid <= 1'b1;
                            s1            <= fb;
                            s2            <= s1;
                            s3            <= s2;
                            count         <= count + 1'b1;
                            if (count == k_last) begin
                                state        <= TAIL;
                                tcnt         <= '0;
                                bus.tailbits <= 1'b1;
                            end
                        end
                    end
                    TAIL: begin
                        // Forcing u = s2^s3 zeroes the feedback, so the register drains to zero.
                        bus.x         <= s2 ^ s3;
                        bus.z         <= s1 ^ s3;
                        bus.out_valid <= 1'b1;
                        s1            <= 1'b0;
                        s2            <= s1;
                        s3            <= s2;
                        if (tcnt == 2'd2) begin
                            state    <= IDLE;
                            tcnt     <= '0;
                            bus.done <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rsc_constituent_encoder.sv
module tb_rsc_constituent_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rsc_constituent_encoder_if #(.KW(13)) bus();

    rsc_constituent_encoder #(.KW(13), .KMIN(40), .KMAX(6144)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic x;
        logic z;
        logic tail;
    } exp_t;

    exp_t sb[$];
    logic zlog[$];
    int   checks = 0;
    int   errors = 0;
    int   ov_cnt = 0;
    int   tb_cnt = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;
    exp_t mon_e;
    logic m_s1, m_s2, m_s3;

`ifdef RSC_ABORT_EN
    initial bus.abort = 1'b0;
`endif

    // Scoreboard monitor: every out_valid pops one expected {x,z}; tail entries also check q0^q1.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.tailbits) tb_cnt++;
            if (bus.done) done_cnt++;
            if (bus.out_valid) begin
                ov_cnt++;
                zlog.push_back(bus.z);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: out_valid with x=%b z=%b, required no output", bus.x, bus.z);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.x, bus.z} !== {mon_e.x, mon_e.z}) begin
                        errors++;
                        $display("FAIL sb_xz: got x=%b z=%b, required x=%b z=%b (tail=%b)",
                                 bus.x, bus.z, mon_e.x, mon_e.z, mon_e.tail);
                    end
                    if (mon_e.tail) begin
                        checks++;
                        if ((bus.q0 ^ bus.q1) !== bus.x) begin
                            errors++;
                            $display("FAIL tail_q: q0^q1=%b, required x=%b", bus.q0 ^ bus.q1, bus.x);
                        end
                    end
                end
            end
        end
    end

    // Runs one block: start, bits until 'stop' accepted, then (if complete) the tail sequence with timing checks.
    task automatic drive_block(input int k, input int mode, input bit gaps, input int stop, input bit busy_start);
        int   n;
        bit   tog;
        bit   prev_acc;
        int   ov0, tb0, dn0;
        logic u, fbm;
        exp_t e;
        n = 0; tog = 1'b1; prev_acc = 1'b0;
        ov0 = ov_cnt; tb0 = tb_cnt; dn0 = done_cnt;
        bus.start = 1'b1;
        bus.k_len = 13'(k);
        @(posedge clk); #1;
        bus.start = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
        while (n < stop) begin
            u = (mode == 0) ? 1'b0 : (mode == 1) ? logic'(n == 0) : logic'($urandom_range(0, 1));
            bus.in_valid = gaps ? tog : 1'b1;
            bus.in_bit   = bus.in_valid ? u : logic'($urandom_range(0, 1));
            if (busy_start && n == 5) begin
                bus.start = 1'b1;
                bus.k_len = 13'd50;
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== prev_acc) begin
                errors++;
                $display("FAIL data_latency bit %0d: out_valid=%b, required %b", n, bus.out_valid, prev_acc);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL data_ready bit %0d: in_ready=%b, required 1", n, bus.in_ready);
            end
            prev_acc = bus.in_valid;
            if (bus.in_valid) begin
                fbm = u ^ m_s2 ^ m_s3;
                e.x = u; e.z = fbm ^ m_s1 ^ m_s3; e.tail = 1'b0;
                sb.push_back(e);
                m_s3 = m_s2; m_s2 = m_s1; m_s1 = fbm;
                n++;
            end
            tog = ~tog;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (stop < k) return;
        for (int j = 0; j < 3; j++) begin
            e.x = m_s2 ^ m_s3; e.z = m_s1 ^ m_s3; e.tail = 1'b1;
            sb.push_back(e);
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = 1'b0;
        end
        for (int c = 1; c <= 4; c++) begin
            bus.in_valid = (c < 4);
            bus.in_bit   = logic'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL tail_valid c%0d: out_valid=%b, required 1", c, bus.out_valid);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL tail_ready c%0d: in_ready=%b, required 0", c, bus.in_ready);
            end
            checks++;
            if (bus.tailbits !== (c == 1)) begin
                errors++;
                $display("FAIL tail_strobe c%0d: tailbits=%b, required %b", c, bus.tailbits, (c == 1));
            end
            checks++;
            if (bus.done !== (c == 4)) begin
                errors++;
                $display("FAIL done_timing c%0d: done=%b, required %b", c, bus.done, (c == 4));
            end
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (ov_cnt - ov0 !== k + 3) begin
            errors++;
            $display("FAIL ov_count: got %0d out_valid cycles, required %0d", ov_cnt - ov0, k + 3);
        end
        checks++;
        if (tb_cnt - tb0 !== 1) begin
            errors++;
            $display("FAIL tailbits_count: got %0d, required 1", tb_cnt - tb0);
        end
        checks++;
        if (done_cnt - dn0 !== 1) begin
            errors++;
            $display("FAIL done_count: got %0d, required 1", done_cnt - dn0);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_left: %0d expected outputs never seen, required 0", sb.size());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        outs = {bus.in_ready, bus.out_valid, bus.x, bus.z, bus.q0, bus.q1,
                bus.tailbits, bus.busy, bus.done, bus.len_err};
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000000000", outs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: busy/in_ready/out_valid=%b, required 000",
                     {bus.busy, bus.in_ready, bus.out_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zeros();
        drive_block(40, 0, 1'b0, 40, 1'b0);
        idle(2);
    endtask

    task automatic test_impulse();
        logic zexp[7];
        zexp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        zlog.delete();
        drive_block(40, 1, 1'b0, 40, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (zlog.size() <= i || zlog[i] !== zexp[i]) begin
                errors++;
                $display("FAIL impulse_z bit %0d: got %b, required %b", i,
                         (zlog.size() > i) ? zlog[i] : 1'bx, zexp[i]);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.q0, bus.q1} !== 2'b00) begin
            errors++;
            $display("FAIL terminated_state: q0q1=%b, required 00", {bus.q0, bus.q1});
        end
        idle(1);
    endtask

    task automatic test_len_err();
        int bad[2];
        bad = '{39, 6145};
        for (int i = 0; i < 2; i++) begin
            bus.start = 1'b1;
            bus.k_len = 13'(bad[i]);
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.len_err, bus.busy, bus.in_ready} !== 3'b100) begin
                errors++;
                $display("FAIL len_err_pulse k=%0d: len_err/busy/in_ready=%b, required 100",
                         bad[i], {bus.len_err, bus.busy, bus.in_ready});
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({bus.len_err, bus.busy, bus.in_ready, bus.out_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL len_err_after k=%0d: len_err/busy/in_ready/out_valid=%b, required 0000",
                         bad[i], {bus.len_err, bus.busy, bus.in_ready, bus.out_valid});
            end
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gaps();
        drive_block(40, 2, 1'b1, 40, 1'b0);
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [9:0] outs;
        int         dn0;
        drive_block(40, 2, 1'b0, 20, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        outs = {bus.in_ready, bus.out_valid, bus.x, bus.z, bus.q0, bus.q1,
                bus.tailbits, bus.busy, bus.done, bus.len_err};
        checks++;
        if (outs !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, required 0000000000", outs);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_sb: %0d pending, required 0", sb.size());
        end
        sb.delete();
        dn0 = done_cnt;
        idle(6);
        checks++;
        if (done_cnt !== dn0) begin
            errors++;
            $display("FAIL reset_mid_done: %0d done pulses, required 0", done_cnt - dn0);
        end
        zlog.delete();
        drive_block(40, 1, 1'b0, 40, 1'b0);
        checks++;
        if (zlog.size() < 4 || {zlog[0], zlog[1], zlog[2], zlog[3]} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid_reencode: first z bits differ from power-on block, required 1111");
        end
        idle(2);
    endtask

    task automatic test_busy_start();
        drive_block(40, 2, 1'b0, 40, 1'b1);
        idle(2);
    endtask

    task automatic test_back_to_back();
        drive_block(40, 2, 1'b0, 40, 1'b0);
        drive_block(41, 2, 1'b0, 41, 1'b0);
        idle(2);
    endtask

    task automatic test_kmax();
        drive_block(6144, 2, 1'b0, 6144, 1'b0);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_impulse();
        test_len_err();
        test_gaps();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        test_kmax();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
